// File: rtl/xosera_bus_initiator_pkg.sv
// Shared state encoding and bus-level constants for the Xosera bus initiator.
package xv;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_RELEASE,
      ST_HOLD,
      ST_DONE
   } state_t;

   localparam logic CS_ENABLED  = 1'b0;
   localparam logic RnW_READ    = 1'b1;
   localparam logic RnW_WRITE   = 1'b0;
   localparam logic BYTESEL_HI  = 1'b0;
   localparam logic BYTESEL_LO  = 1'b1;

endpackage

// File: rtl/xosera_bus_initiator_sync.sv
// Multi-bit 2-flop synchronizer for asynchronous responder strobes.
module xosera_sync #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/xosera_bus_initiator.sv
// Splits 16-bit register requests into two DTACK-closed byte strobes on Xosera's 8-bit bus.
// Optional feature: define XOSERA_BUS_TIMEOUT_EN to abort strobes whose DTACK never arrives or releases.
module xosera_bus_initiator
   import xv::*;
#(
   parameter int SETUP_CYCLES   = 1,
   parameter int HOLD_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [3:0]  req_reg_i,
   input  logic [15:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [15:0] rsp_rdata_o,
   output logic        rsp_timeout_o,
   output logic        bus_cs_n_o,
   output logic        bus_rd_nwr_o,
   output logic        bus_bytesel_o,
   output logic [3:0]  bus_reg_num_o,
   output logic [7:0]  bus_data_o,
   output logic        bus_data_oe_o,
   input  logic [7:0]  bus_data_i,
   input  logic        bus_dtack_n_i,
   input  logic        bus_irq_n_i,
   output logic        irq_o
);

   if (SETUP_CYCLES < 1 || SETUP_CYCLES > 7) begin : g_bad_setup
      $error("SETUP_CYCLES must be 1..7");
   end
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 7) begin : g_bad_hold
      $error("HOLD_CYCLES must be 1..7");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be 1..255");
   end

   localparam logic [7:0] C_SETUP_LAST = 8'(SETUP_CYCLES - 1);
   localparam logic [7:0] C_HOLD_LAST  = 8'(HOLD_CYCLES - 1);

   logic [1:0] w_sync;
   logic       w_dtack_n;

   xosera_sync #(
      .WIDTH     (2),
      .RESET_VAL (2'b11)
   ) u_sync (
      .clk       (clk),
      .reset_n_i (reset_n_i),
      .d_i       ({bus_dtack_n_i, bus_irq_n_i}),
      .q_o       (w_sync)
   );

   assign w_dtack_n = w_sync[1];
   assign irq_o     = ~w_sync[0];

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic        r_write;
   logic [7:0]  r_wdata_lo;
   logic [15:0] r_rdata;
   logic        r_ready;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_rdata;
   logic        r_cs_n;
   logic        r_rd_nwr;
   logic        r_bytesel;
   logic [3:0]  r_reg_num;
   logic [7:0]  r_data;
   logic        r_oe;
`ifdef XOSERA_BUS_TIMEOUT_EN
   localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic        r_timed_out;
   logic        r_rsp_timeout;
`endif

   // r_cnt is shared: setup/hold pacing, and DTACK wait time in STROBE/RELEASE.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_write     <= 1'b0;
         r_wdata_lo  <= '0;
         r_rdata     <= '0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_cs_n      <= ~CS_ENABLED;
         r_rd_nwr    <= RnW_READ;
         r_bytesel   <= BYTESEL_HI;
         r_reg_num   <= '0;
         r_data      <= '0;
         r_oe        <= 1'b0;
`ifdef XOSERA_BUS_TIMEOUT_EN
         r_timed_out   <= 1'b0;
         r_rsp_timeout <= 1'b0;
`endif
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_ready && req_valid_i) begin
                  r_ready    <= 1'b0;
                  r_write    <= req_write_i;
                  r_wdata_lo <= req_wdata_i[7:0];
                  r_rdata    <= '0;
                  r_reg_num  <= req_reg_i;
                  r_rd_nwr   <= req_write_i ? RnW_WRITE : RnW_READ;
                  r_bytesel  <= BYTESEL_HI;
                  r_data     <= req_write_i ? req_wdata_i[15:8] : 8'h00;
                  r_oe       <= req_write_i;
                  r_cnt      <= '0;
`ifdef XOSERA_BUS_TIMEOUT_EN
                  r_timed_out <= 1'b0;
`endif
                  r_state    <= ST_SETUP;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_SETUP: begin
               if (r_cnt == C_SETUP_LAST) begin
                  r_cnt   <= '0;
                  r_cs_n  <= CS_ENABLED;
                  r_state <= ST_STROBE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_STROBE: begin
               if (!w_dtack_n) begin
                  if (!r_write) begin
                     if (r_bytesel == BYTESEL_HI) r_rdata[15:8] <= bus_data_i;
                     else                         r_rdata[7:0]  <= bus_data_i;
                  end
                  r_cnt   <= '0;
                  r_cs_n  <= ~CS_ENABLED;
                  r_state <= ST_RELEASE;
               end
`ifdef XOSERA_BUS_TIMEOUT_EN
               else if (r_cnt == C_TMO_LAST) begin
                  r_cs_n      <= ~CS_ENABLED;
                  r_oe        <= 1'b0;
                  r_timed_out <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
`endif
            end
            ST_RELEASE: begin
               if (w_dtack_n) begin
                  r_cnt <= '0;
                  if (r_bytesel == BYTESEL_HI) begin
                     r_bytesel <= BYTESEL_LO;
                     r_data    <= r_write ? r_wdata_lo : 8'h00;
                     r_state   <= ST_HOLD;
                  end else begin
                     r_oe    <= 1'b0;
                     r_state <= ST_DONE;
                  end
               end
`ifdef XOSERA_BUS_TIMEOUT_EN
               else if (r_cnt == C_TMO_LAST) begin
                  r_oe        <= 1'b0;
                  r_timed_out <= 1'b1;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
`endif
            end
            ST_HOLD: begin
               if (r_cnt == C_HOLD_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_SETUP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_DONE: begin
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= r_rdata;
               r_rd_nwr    <= RnW_READ;
               r_oe        <= 1'b0;
               r_ready     <= 1'b1;
`ifdef XOSERA_BUS_TIMEOUT_EN
               r_rsp_timeout <= r_timed_out;
`endif
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o   = r_ready;
   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_rdata_o   = r_rsp_rdata;
   assign bus_cs_n_o    = r_cs_n;
   assign bus_rd_nwr_o  = r_rd_nwr;
   assign bus_bytesel_o = r_bytesel;
   assign bus_reg_num_o = r_reg_num;
   assign bus_data_o    = r_data;
   assign bus_data_oe_o = r_oe;
`ifdef XOSERA_BUS_TIMEOUT_EN
   assign rsp_timeout_o = r_rsp_timeout;
`else
   assign rsp_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_xosera_bus_initiator.sv
// Directed + randomized bench for xosera_bus_initiator with a behavioural DTACK responder.
// Timeout scenarios are exercised only when XOSERA_BUS_TIMEOUT_EN is defined.
module tb_xosera_bus_initiator;

   localparam int SETUP = 1;
   localparam int HOLD  = 1;
   localparam int TMO   = 255;

   logic        clk = 1'b0;
   logic        reset_n_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [3:0]  req_reg_i;
   logic [15:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [15:0] rsp_rdata_o;
   logic        rsp_timeout_o;
   logic        bus_cs_n_o;
   logic        bus_rd_nwr_o;
   logic        bus_bytesel_o;
   logic [3:0]  bus_reg_num_o;
   logic [7:0]  bus_data_o;
   logic        bus_data_oe_o;
   logic [7:0]  bus_data_i;
   logic        bus_dtack_n_i;
   logic        bus_irq_n_i;
   logic        irq_o;

   xosera_bus_initiator #(
      .SETUP_CYCLES   (SETUP),
      .HOLD_CYCLES    (HOLD),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .reset_n_i     (reset_n_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_write_i   (req_write_i),
      .req_reg_i     (req_reg_i),
      .req_wdata_i   (req_wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_timeout_o (rsp_timeout_o),
      .bus_cs_n_o    (bus_cs_n_o),
      .bus_rd_nwr_o  (bus_rd_nwr_o),
      .bus_bytesel_o (bus_bytesel_o),
      .bus_reg_num_o (bus_reg_num_o),
      .bus_data_o    (bus_data_o),
      .bus_data_oe_o (bus_data_oe_o),
      .bus_data_i    (bus_data_i),
      .bus_dtack_n_i (bus_dtack_n_i),
      .bus_irq_n_i   (bus_irq_n_i),
      .irq_o         (irq_o)
   );

   typedef struct {
      logic       rdnwr;
      logic       bsel;
      logic [3:0] rg;
      logic [7:0] dat;
      logic       oe;
   } strobe_t;

   typedef struct {
      int          cyc;
      logic [15:0] rdata;
      logic        tmo;
   } rsp_t;

   int nVectors = 0;
   int nMiss    = 0;
   int cyc      = 0;

   // Responder behaviour: 0 = normal, 1 = never acknowledge, 2 = DTACK stuck low after first ack
   int         rspDelay = 0;
   int         rspMode  = 0;
   logic [7:0] rspHi    = 8'h00;
   logic [7:0] rspLo    = 8'h00;
   int         ackWait  = 0;

   strobe_t strobeQ[$];
   int      widthQ[$];
   rsp_t    rspQ[$];
   int      acceptQ[$];
   int      oeViol = 0;
   int      minGap = 1000;

   initial forever #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Responder: reacts on the falling edge so its strobes are asynchronous to the DUT clock edge.
   initial begin
      bus_dtack_n_i = 1'b1;
      bus_data_i    = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset_n_i) begin
            ackWait       = 0;
            bus_dtack_n_i = 1'b1;
         end else if (bus_cs_n_o == 1'b0) begin
            if (rspMode != 1) begin
               if (ackWait >= rspDelay) begin
                  bus_dtack_n_i = 1'b0;
                  bus_data_i    = bus_bytesel_o ? rspLo : rspHi;
               end else begin
                  ackWait++;
               end
            end
         end else begin
            ackWait = 0;
            if (rspMode != 2) bus_dtack_n_i = 1'b1;
         end
      end
   end

   // Passive monitor: strobes, strobe widths, gaps, accepts and responses.
   initial begin
      strobe_t s;
      rsp_t    r;
      logic    prevCs;
      int      lowCnt;
      int      gap;
      prevCs = 1'b1;
      lowCnt = 0;
      gap    = 1000;
      forever begin
         @(negedge clk);
         if (bus_data_oe_o && bus_rd_nwr_o) oeViol++;
         if (req_valid_i && req_ready_o) acceptQ.push_back(cyc + 1);
         if (rsp_valid_o) begin
            r.cyc   = cyc;
            r.rdata = rsp_rdata_o;
            r.tmo   = rsp_timeout_o;
            rspQ.push_back(r);
         end
         if (!bus_cs_n_o) begin
            if (prevCs) begin
               s.rdnwr = bus_rd_nwr_o;
               s.bsel  = bus_bytesel_o;
               s.rg    = bus_reg_num_o;
               s.dat   = bus_data_o;
               s.oe    = bus_data_oe_o;
               strobeQ.push_back(s);
               if (gap < minGap) minGap = gap;
               lowCnt = 0;
            end
            lowCnt++;
         end else begin
            if (!prevCs) begin
               widthQ.push_back(lowCnt);
               gap = 0;
            end
            gap++;
         end
         prevCs = bus_cs_n_o;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVectors++;
      assert (obs === exp)
      else begin
         nMiss++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One request against the responder model; expectations come from the byte-split rules.
   task automatic applyStimulus(input string name, input logic wr, input logic [3:0] rg,
                                input logic [15:0] wd, input logic [7:0] hi, input logic [7:0] lo,
                                input int dly, input int mode);
      int          nExp;
      int          expLat;
      logic [15:0] expRdata;
      logic [7:0]  expByte;
      rspDelay = dly;
      rspMode  = mode;
      rspHi    = hi;
      rspLo    = lo;
      repeat (4) @(posedge clk);
      #1;
      strobeQ.delete(); widthQ.delete(); rspQ.delete(); acceptQ.delete();
      oeViol = 0;
      minGap = 1000;
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_reg_i   = rg;
      req_wdata_i = wd;
      for (int i = 0; i < 40 && acceptQ.size() == 0; i++) begin
         @(posedge clk);
         #1;
      end
      req_valid_i = 1'b0;
      checkOutput($sformatf("%s accept", name), 32'(acceptQ.size()), 32'd1);
      for (int i = 0; i < 800 && rspQ.size() == 0; i++) begin
         @(posedge clk);
         #1;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput($sformatf("%s rsp_pulses", name), 32'(rspQ.size()), 32'd1);
      nExp     = (mode == 0) ? 2 : 1;
      expRdata = (mode == 0) ? {hi, lo} : ((mode == 2) ? {hi, 8'h00} : 16'h0000);
      checkOutput($sformatf("%s strobes", name), 32'(strobeQ.size()), 32'(nExp));
      for (int b = 0; b < nExp && b < strobeQ.size(); b++) begin
         expByte = (b == 0) ? wd[15:8] : wd[7:0];
         checkOutput($sformatf("%s s%0d reg", name, b), 32'(strobeQ[b].rg), 32'(rg));
         checkOutput($sformatf("%s s%0d rd_nwr", name, b), 32'(strobeQ[b].rdnwr), 32'(!wr));
         checkOutput($sformatf("%s s%0d bytesel", name, b), 32'(strobeQ[b].bsel), 32'(b));
         checkOutput($sformatf("%s s%0d oe", name, b), 32'(strobeQ[b].oe), 32'(wr));
         if (wr) checkOutput($sformatf("%s s%0d data", name, b), 32'(strobeQ[b].dat), 32'(expByte));
      end
      checkOutput($sformatf("%s oe_while_read", name), 32'(oeViol), 32'd0);
      if (rspQ.size() > 0) begin
         checkOutput($sformatf("%s timeout", name), 32'(rspQ[0].tmo), 32'(mode != 0));
         if (!wr) checkOutput($sformatf("%s rdata", name), 32'(rspQ[0].rdata), 32'(expRdata));
         if (mode == 0 && acceptQ.size() > 0) begin
            expLat = 2 * (SETUP + 1 + 2 + dly + 1 + 2) + HOLD + 1;
            checkOutput($sformatf("%s latency", name), 32'(rspQ[0].cyc - acceptQ[0]), 32'(expLat));
         end
      end
      if (mode == 0 && widthQ.size() > 0)
         checkOutput($sformatf("%s strobe_width", name), 32'(widthQ[0]), 32'(dly + 3));
      if (mode == 1 && widthQ.size() > 0)
         checkOutput($sformatf("%s timeout_width", name), 32'(widthQ[0]), 32'(TMO));
      rspMode = 0;
   endtask

   initial begin
      reset_n_i   = 1'b0;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_reg_i   = 4'h0;
      req_wdata_i = 16'h0000;
      bus_irq_n_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst ready", 32'(req_ready_o), 32'd0);
      checkOutput("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rst rdata", 32'(rsp_rdata_o), 32'd0);
      checkOutput("rst timeout", 32'(rsp_timeout_o), 32'd0);
      checkOutput("rst cs_n", 32'(bus_cs_n_o), 32'd1);
      checkOutput("rst rd_nwr", 32'(bus_rd_nwr_o), 32'd1);
      checkOutput("rst bytesel", 32'(bus_bytesel_o), 32'd0);
      checkOutput("rst reg_num", 32'(bus_reg_num_o), 32'd0);
      checkOutput("rst data", 32'(bus_data_o), 32'd0);
      checkOutput("rst oe", 32'(bus_data_oe_o), 32'd0);
      checkOutput("rst irq", 32'(irq_o), 32'd0);
      reset_n_i = 1'b1;
      #1;
      checkOutput("ready before first clock", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("ready after first clock", 32'(req_ready_o), 32'd1);

      applyStimulus("write_a55a", 1'b1, 4'h3, 16'hA55A, 8'h00, 8'h00, 3, 0);
      applyStimulus("read_1234", 1'b0, 4'hC, 16'h0000, 8'h12, 8'h34, 0, 0);
      applyStimulus("write_fast", 1'b1, 4'hF, 16'h00FF, 8'h00, 8'h00, 0, 0);

      for (int n = 0; n < 8; n++) begin
         applyStimulus($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 4'($urandom),
                       16'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), 0);
      end

`ifdef XOSERA_BUS_TIMEOUT_EN
      applyStimulus("strobe_timeout", 1'b0, 4'h7, 16'h0000, 8'hAA, 8'hBB, 0, 1);
      applyStimulus("release_timeout", 1'b0, 4'h2, 16'h0000, 8'h9C, 8'h33, 1, 2);
      applyStimulus("after_timeout", 1'b0, 4'h1, 16'h0000, 8'h5E, 8'hE5, 0, 0);
`endif

      // Back-to-back: valid held high across two requests
      rspMode  = 0;
      rspDelay = 0;
      repeat (4) @(posedge clk);
      #1;
      strobeQ.delete(); widthQ.delete(); rspQ.delete(); acceptQ.delete();
      minGap = 1000;
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_reg_i   = 4'h5;
      req_wdata_i = 16'h1111;
      for (int i = 0; i < 40 && acceptQ.size() == 0; i++) begin
         @(posedge clk);
         #1;
      end
      req_reg_i   = 4'h6;
      req_wdata_i = 16'h2233;
      for (int i = 0; i < 100 && acceptQ.size() < 2; i++) begin
         @(posedge clk);
         #1;
      end
      req_valid_i = 1'b0;
      for (int i = 0; i < 100 && rspQ.size() < 2; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("b2b accepts", 32'(acceptQ.size()), 32'd2);
      checkOutput("b2b rsps", 32'(rspQ.size()), 32'd2);
      checkOutput("b2b strobes", 32'(strobeQ.size()), 32'd4);
      if (acceptQ.size() == 2 && rspQ.size() == 2)
         checkOutput("b2b second accept after rsp", 32'(acceptQ[1] > rspQ[0].cyc), 32'd1);
      if (strobeQ.size() == 4) begin
         checkOutput("b2b s2 reg", 32'(strobeQ[2].rg), 32'h6);
         checkOutput("b2b s2 data", 32'(strobeQ[2].dat), 32'h22);
         checkOutput("b2b s3 data", 32'(strobeQ[3].dat), 32'h33);
      end
      checkOutput("b2b min cs_n high gap", 32'(minGap >= HOLD), 32'd1);

      // Interrupt synchronizer: two clocks of sense latency
      @(posedge clk);
      #1;
      bus_irq_n_i = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("irq after 1 clk", 32'(irq_o), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("irq after 2 clk", 32'(irq_o), 32'd1);
      bus_irq_n_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("irq released", 32'(irq_o), 32'd0);

      // Reset asserted mid-strobe
      rspMode  = 0;
      rspDelay = 20;
      repeat (4) @(posedge clk);
      #1;
      rspQ.delete(); acceptQ.delete();
      req_valid_i = 1'b1;
      req_write_i = 1'b1;
      req_reg_i   = 4'h9;
      req_wdata_i = 16'hBEEF;
      for (int i = 0; i < 40 && acceptQ.size() == 0; i++) begin
         @(posedge clk);
         #1;
      end
      req_valid_i = 1'b0;
      for (int i = 0; i < 40 && bus_cs_n_o; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("mid-reset strobe reached", 32'(bus_cs_n_o), 32'd0);
      #2;
      reset_n_i = 1'b0;
      #1;
      checkOutput("mid-reset cs_n", 32'(bus_cs_n_o), 32'd1);
      checkOutput("mid-reset oe", 32'(bus_data_oe_o), 32'd0);
      checkOutput("mid-reset ready", 32'(req_ready_o), 32'd0);
      @(posedge clk);
      #1;
      reset_n_i = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      checkOutput("mid-reset no rsp", 32'(rspQ.size()), 32'd0);
      applyStimulus("after_reset", 1'b0, 4'hA, 16'h0000, 8'hC3, 8'h3C, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule
